// File: rtl/fetch_queue.sv
// Instruction fetch stage: reads instruction memory at the PC over a req/ack
// handshake, queues {pc, instruction} for decode and pulses pc_push to advance.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int AW    = 30
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   pc_addr,
  output logic          pc_push,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [31:0]   imem_rdata,
  input  logic          flush,
  output logic          ir_valid,
  input  logic          ir_ready,
  output logic [31:0]   ir_data,
  output logic [31:0]   ir_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, ADV, DROP} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] req_addr_q, req_addr_d;
  logic [31:0]   data_q [DEPTH];
  logic [AW-1:0] pcs_q  [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          wr_en;
  logic          rd_en;
  logic          unused_pc_hi;

  assign unused_pc_hi = ^pc_addr[31:AW];

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    wr_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!flush && (count_q < DepthC)) begin
          req_addr_d = pc_addr[AW-1:0];
          state_d    = REQ;
        end
      end
      REQ: begin
        // A flush that races the ack wins: the returned word belongs to the old path.
        if (imem_ack && flush) begin
          state_d = IDLE;
        end else if (imem_ack) begin
          wr_en   = 1'b1;
          state_d = ADV;
        end else if (flush) begin
          state_d = DROP;
        end
      end
      ADV:     state_d = IDLE;
      DROP: begin
        if (imem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
    end
  end

  assign ir_valid = (count_q != '0);
  assign rd_en    = ir_valid && ir_ready && !flush;

  // Pointers are PW bits wide so they wrap modulo DEPTH without extra logic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pcs_q[i]  <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) begin
        data_q[wptr_q] <= imem_rdata;
        pcs_q[wptr_q]  <= req_addr_q;
        wptr_q         <= wptr_q + 1'b1;
      end
      if (rd_en) begin
        rptr_q <= rptr_q + 1'b1;
      end
      count_q <= count_q + CW'(wr_en) - CW'(rd_en);
    end
  end

  assign imem_req  = (state_q == REQ) || (state_q == DROP);
  assign imem_addr = req_addr_q;
  assign pc_push   = (state_q == ADV);
  assign ir_data   = data_q[rptr_q];
  assign ir_pc     = 32'(pcs_q[rptr_q]);

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch stage that sits directly downstream of the PC block. It takes the current word address and reads the instruction from instruction memory over a req/ack handshake. It buffers the fetched instruction with its PC in a small FIFO for decode, then pulses `pc_push` so the PC block advances. A flush input discards everything in flight after a taken branch or jump.

## Interface
- `DEPTH`, 2: FIFO entries (power of two, ≥2).
- `AW`, 30: instruction-memory word-address width.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `pc_addr`  in  32  current word address from PC block.
- `pc_push`  out  1  one-cycle pulse requesting the PC block to advance.
- `imem_req`  out  1  memory read request; held until acked.
- `imem_addr`  out  AW  word address, equals `pc_addr[AW-1:0]` latched at request start.
- `imem_ack`  in  1  read complete; `imem_rdata` valid in the same cycle.
- `imem_rdata`  in  32  instruction word.
- `flush`  in  1  discard queue and any outstanding fetch.
- `ir_valid`  out  1  FIFO head valid.
- `ir_ready`  in  1  decode accepts head.
- `ir_data`  out  32  head instruction.
- `ir_pc`  out  32  head word address (zero-extended from AW).

## Operation
- FSM states: IDLE, REQ, ADV, DROP.
- IDLE:
  - If `!flush` and `count < DEPTH`: latch `pc_addr` into `req_addr` and go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - `imem_req` = 1, `imem_addr` = `req_addr`.
  - On `imem_ack` without flush: write {`req_addr`, `imem_rdata`} to the FIFO, pulse `pc_push` next cycle, go to ADV.
  - On `flush` without ack: go to DROP.
  - On `flush` with ack in the same cycle: drop the data, no `pc_push`, go to IDLE.
- ADV:
  - `pc_push` = 1 for exactly this cycle; the PC block updates on this edge.
  - Return to IDLE; `pc_addr` is sampled no earlier than the following cycle.
- DROP:
  - `imem_req` = 1, held until ack, as required by the memory protocol.
  - On `imem_ack`: discard data, go to IDLE.
  - No FIFO write and no `pc_push`.
- FIFO:
  - Write only from REQ with ack.
  - Pop when `ir_valid && ir_ready`.
  - Simultaneous write and pop leaves `count` unchanged.
  - Write is never attempted when full, because IDLE gates on `count < DEPTH`.
  - Read/write pointers wrap modulo DEPTH.
- Flush:
  - Highest priority.
  - Clears `count` and pointers and deasserts `ir_valid` on the next edge.
  - A pop in the same cycle as flush is ignored.
  - Flush in ADV: `pc_push` is still issued, because the PC has already committed; then go to IDLE.
  - Flush in IDLE: stay in IDLE that cycle.
- Width: `ir_pc` = {(32-AW)'b0, req_addr}. `pc_addr` bits above AW are ignored.

## Timing
- Reset values, asynchronous on `reset`=0:
  - FSM state: IDLE.
  - `imem_req`=0, `imem_addr`=0, `pc_push`=0.
  - `ir_valid`=0, `ir_data`=0, `ir_pc`=0.
  - `count`=0 and both pointers = 0.
- Deassertion of reset takes effect at the first rising edge with `reset`=1.
- `imem_req` rises the cycle after IDLE decides to fetch.
- `imem_ack` is sampled only while `imem_req`=1.
- Best-case throughput (ack in the first REQ cycle): one instruction per 3 cycles (IDLE→REQ→ADV).
- Latency: `ir_valid` = 1 the cycle after the ack edge.
- Outputs are registered; `ir_data`/`ir_pc` are show-ahead, valid whenever `ir_valid`=1.
- Reset asserted mid-REQ drops `imem_req` immediately (asynchronous). The memory side must tolerate the abandoned request.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with random inputs -> all outputs 0, no `pc_push`; release -> first `imem_req` on the 2nd edge, `imem_addr`=`pc_addr`.
- Single fetch: `pc_addr`=0x10, ack after 2 wait cycles with rdata 0x8C220004, `ir_ready`=1 -> `ir_valid` for one cycle with `ir_data`=0x8C220004, `ir_pc`=0x10; exactly one `pc_push` pulse.
- Back-pressure: `ir_ready`=0, PC stepping 0,1,2 -> two entries queued (pc 0,1), no third `imem_req`; raise `ir_ready` -> pops in order 0,1, then fetch of pc 2 resumes.
- Flush mid-request: flush while in REQ, ack 3 cycles later -> DROP holds `imem_req` until ack; no FIFO write, no `pc_push`; `ir_valid`=0.
- Flush coincident with ack, and flush while FIFO full with `ir_ready`=1 -> data dropped, FIFO empty next cycle, no pop counted.
- Simultaneous write/pop at `count`=1 with pointer wrap (DEPTH=2, ten instructions) -> count stays 1, order preserved, `ir_pc` sequence 0..9.
